// File: rtl/id_ex_pkg.sv
// ID/EX shared definitions: control bundle layout,
// special register numbers and ALU op encodings.
package id_ex_pkg;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int BRANCH     = 6;
  localparam int IS_JAL     = 7;
  localparam int ALU_OP_LO  = 8;
  localparam int ALU_OP_HI  = 10;

  localparam int ZERO_REG = 0;
  localparam int LINK_REG = 31;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    is_jal;
    logic    branch;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    mem_write;
    logic    mem_read;
    logic    reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/write-back inputs and EX-slot outputs of the ID/EX stage.
// The stage is the slave; the surrounding pipeline is the master.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) ();

  logic              id_valid_i;
  logic [DATA_W-1:0] pc_add4_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              uses_rt_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              wb_reg_write_i;
  logic              wb_is_jal_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [DATA_W-1:0] wb_pc_add4_i;
  logic              flush_i;
  logic              hold_i;

  logic              ex_valid_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [DATA_W-1:0] ex_pc_add4_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [ADDR_W-1:0] ex_rs_addr_o;
  logic [ADDR_W-1:0] ex_rt_addr_o;
  logic [ADDR_W-1:0] ex_rd_addr_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, pc_add4_i,
    output rs_addr_i, rt_addr_i, rd_addr_i,
    output uses_rt_i, rs_data_i, rt_data_i,
    output imm_i, ctrl_i,
    output wb_reg_write_i, wb_is_jal_i,
    output wb_addr_i, wb_data_i, wb_pc_add4_i,
    output flush_i, hold_i,
    input  ex_valid_o, ex_ctrl_o, ex_pc_add4_o,
    input  ex_rs_data_o, ex_rt_data_o, ex_imm_o,
    input  ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
    input  stall_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, pc_add4_i,
    input  rs_addr_i, rt_addr_i, rd_addr_i,
    input  uses_rt_i, rs_data_i, rt_data_i,
    input  imm_i, ctrl_i,
    input  wb_reg_write_i, wb_is_jal_i,
    input  wb_addr_i, wb_data_i, wb_pc_add4_i,
    input  flush_i, hold_i,
    output ex_valid_o, ex_ctrl_o, ex_pc_add4_o,
    output ex_rs_data_o, ex_rt_data_o, ex_imm_o,
    output ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
    output stall_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_unit.sv
// Load-use compare between the load sitting in EX
// and the source registers of the decode instruction.
module hazard_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              id_valid_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_rt_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic              uses_rt_i,
  output logic              hz_o
);
  import id_ex_pkg::*;

  logic ld_live;
  logic rs_hit;
  logic rt_hit;

  assign ld_live = id_valid_i & ex_valid_i & ex_mem_read_i
                 & (ex_rt_addr_i != ADDR_W'(ZERO_REG));
  assign rs_hit  = (ex_rt_addr_i == rs_addr_i);
  assign rt_hit  = uses_rt_i & (ex_rt_addr_i == rt_addr_i);
  assign hz_o    = ld_live & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass,
// load-use bubble insertion and saturating stall/flush counters.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 11,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);
  import id_ex_pkg::*;

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [DATA_W-1:0] ex_pc_q;
  logic [DATA_W-1:0] ex_rs_q;
  logic [DATA_W-1:0] ex_rt_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [ADDR_W-1:0] ex_rsa_q;
  logic [ADDR_W-1:0] ex_rta_q;
  logic [ADDR_W-1:0] ex_rda_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_val;
  logic              rs_byp;
  logic              rt_byp;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              hz;
  logic              kill;

  // RF write and read in the same cycle miss each other, so bypass here
  assign wb_dst = bus.wb_is_jal_i ? ADDR_W'(LINK_REG)
                                  : bus.wb_addr_i;
  assign wb_val = bus.wb_is_jal_i ? bus.wb_pc_add4_i
                                  : bus.wb_data_i;

  assign rs_byp = bus.wb_reg_write_i
                & (wb_dst == bus.rs_addr_i)
                & (bus.rs_addr_i != ADDR_W'(ZERO_REG));
  assign rt_byp = bus.wb_reg_write_i
                & (wb_dst == bus.rt_addr_i)
                & (bus.rt_addr_i != ADDR_W'(ZERO_REG));

  assign rs_fwd = rs_byp ? wb_val : bus.rs_data_i;
  assign rt_fwd = rt_byp ? wb_val : bus.rt_data_i;

  hazard_unit #(
    .ADDR_W (ADDR_W)
  ) u_hazard (
    .id_valid_i    (bus.id_valid_i),
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q[MEM_READ]),
    .ex_rt_addr_i  (ex_rta_q),
    .rs_addr_i     (bus.rs_addr_i),
    .rt_addr_i     (bus.rt_addr_i),
    .uses_rt_i     (bus.uses_rt_i),
    .hz_o          (hz)
  );

  assign bus.stall_o = hz & ~bus.flush_i & ~bus.hold_i;

  // flush beats hold; a load-use bubble only when not held
  assign kill = bus.flush_i | (~bus.hold_i & hz);

  always_ff @(posedge clk_i) begin
    if (rst_i || kill) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_imm_q   <= '0;
      ex_rsa_q   <= '0;
      ex_rta_q   <= '0;
      ex_rda_q   <= '0;
    end else if (!bus.hold_i) begin
      ex_valid_q <= bus.id_valid_i;
      ex_ctrl_q  <= bus.id_valid_i ? bus.ctrl_i : '0;
      ex_pc_q    <= bus.pc_add4_i;
      ex_rs_q    <= rs_fwd;
      ex_rt_q    <= rt_fwd;
      ex_imm_q   <= bus.imm_i;
      ex_rsa_q   <= bus.rs_addr_i;
      ex_rta_q   <= bus.rt_addr_i;
      ex_rda_q   <= bus.rd_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.flush_i) begin
      if (flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end else if (!bus.hold_i && hz) begin
      if (stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.ex_ctrl_o    = ex_ctrl_q;
  assign bus.ex_pc_add4_o = ex_pc_q;
  assign bus.ex_rs_data_o = ex_rs_q;
  assign bus.ex_rt_data_o = ex_rt_q;
  assign bus.ex_imm_o     = ex_imm_q;
  assign bus.ex_rs_addr_o = ex_rsa_q;
  assign bus.ex_rt_addr_o = ex_rta_q;
  assign bus.ex_rd_addr_o = ex_rda_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are
// computed at drive time, queued, and popped after the clock edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [10:0] ctrl;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [4:0]  rda;
  } ex_t;

  localparam logic [10:0] C_LW  = 11'h01B;
  localparam logic [10:0] C_ADD = 11'h021;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  ex_t         q[$];
  ex_t         m;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  function automatic ex_t act();
    ex_t a;
    a.valid = bus.ex_valid_o;
    a.ctrl  = bus.ex_ctrl_o;
    a.pc    = bus.ex_pc_add4_o;
    a.rs    = bus.ex_rs_data_o;
    a.rt    = bus.ex_rt_data_o;
    a.imm   = bus.ex_imm_o;
    a.rsa   = bus.ex_rs_addr_o;
    a.rta   = bus.ex_rt_addr_o;
    a.rda   = bus.ex_rd_addr_o;
    return a;
  endfunction

  function automatic logic [31:0] byp(
    input logic [4:0] a, input logic [31:0] d);
    logic [4:0]  dst;
    logic [31:0] val;
    dst = bus.wb_is_jal_i ? 5'd31 : bus.wb_addr_i;
    val = bus.wb_is_jal_i ? bus.wb_pc_add4_i : bus.wb_data_i;
    if (bus.wb_reg_write_i && a != 5'd0 && a == dst)
      return val;
    return d;
  endfunction

  task automatic clr();
    bus.id_valid_i     = 1'b0;
    bus.pc_add4_i      = '0;
    bus.rs_addr_i      = '0;
    bus.rt_addr_i      = '0;
    bus.rd_addr_i      = '0;
    bus.uses_rt_i      = 1'b0;
    bus.rs_data_i      = '0;
    bus.rt_data_i      = '0;
    bus.imm_i          = '0;
    bus.ctrl_i         = '0;
    bus.wb_reg_write_i = 1'b0;
    bus.wb_is_jal_i    = 1'b0;
    bus.wb_addr_i      = '0;
    bus.wb_data_i      = '0;
    bus.wb_pc_add4_i   = '0;
    bus.flush_i        = 1'b0;
    bus.hold_i         = 1'b0;
  endtask

  task automatic set_instr(
    input logic [10:0] c, input logic [4:0] rs_a,
    input logic [4:0] rt_a, input logic [4:0] rd_a,
    input logic ur);
    bus.id_valid_i = 1'b1;
    bus.ctrl_i     = c;
    bus.rs_addr_i  = rs_a;
    bus.rt_addr_i  = rt_a;
    bus.rd_addr_i  = rd_a;
    bus.uses_rt_i  = ur;
    bus.rs_data_i  = $urandom;
    bus.rt_data_i  = $urandom;
    bus.imm_i      = $urandom;
    bus.pc_add4_i  = $urandom;
  endtask

  // Model one clock edge from the current inputs, queue the result.
  task automatic step();
    ex_t  e;
    logic hz;
    hz = bus.id_valid_i && m.valid && m.ctrl[1] && m.rta != 5'd0
      && (m.rta == bus.rs_addr_i
          || (bus.uses_rt_i && m.rta == bus.rt_addr_i));
    e = m;
    if (rst) begin
      e = '0;
      m_stall = '0;
      m_flush = '0;
    end else if (bus.flush_i) begin
      e = '0;
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end else if (bus.hold_i) begin
      e = m;
    end else if (hz) begin
      e = '0;
      if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end else begin
      e.valid = bus.id_valid_i;
      e.ctrl  = bus.id_valid_i ? bus.ctrl_i : 11'd0;
      e.pc    = bus.pc_add4_i;
      e.rs    = byp(bus.rs_addr_i, bus.rs_data_i);
      e.rt    = byp(bus.rt_addr_i, bus.rt_data_i);
      e.imm   = bus.imm_i;
      e.rsa   = bus.rs_addr_i;
      e.rta   = bus.rt_addr_i;
      e.rda   = bus.rd_addr_i;
    end
    q.push_back(e);
    m = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_t e;
    clr();
    m = '0;
    m_stall = '0;
    m_flush = '0;
    rst = 1'b1;
    step();
    void'(q.pop_front());
    step();
    e = q.pop_front();
    total++;
    if (act() !== e)
      $display("FAIL reset_ex: got %h want %h", act(), e);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0
        || bus.stall_o !== 1'b0)
      $display("FAIL reset_cnt: got %h %h %b want 0 0 0",
               bus.stall_cnt_o, bus.flush_cnt_o, bus.stall_o);
    else passed++;
  endtask

  task automatic test_bypass();
    ex_t e;
    clr();
    set_instr(C_ADD, 5'd8, 5'd3, 5'd4, 1'b1);
    bus.rs_data_i      = 32'h11;
    bus.wb_reg_write_i = 1'b1;
    bus.wb_addr_i      = 5'd8;
    bus.wb_data_i      = 32'hAB;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.ex_rs_data_o !== 32'hAB)
      $display("FAIL bypass_rs: got %h want %h", act(), e);
    else passed++;
    set_instr(C_ADD, 5'd0, 5'd3, 5'd4, 1'b1);
    bus.rs_data_i = 32'h22;
    bus.wb_addr_i = 5'd0;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.ex_rs_data_o !== 32'h22)
      $display("FAIL bypass_zero: got %h want %h", act(), e);
    else passed++;
    set_instr(C_ADD, 5'd5, 5'd5, 5'd4, 1'b1);
    bus.wb_reg_write_i = 1'b0;
    bus.wb_addr_i      = 5'd5;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e)
      $display("FAIL bypass_nowr: got %h want %h", act(), e);
    else passed++;
  endtask

  task automatic test_jal();
    ex_t e;
    clr();
    set_instr(C_ADD, 5'd2, 5'd31, 5'd4, 1'b1);
    bus.rt_data_i      = 32'h5;
    bus.wb_reg_write_i = 1'b1;
    bus.wb_is_jal_i    = 1'b1;
    bus.wb_addr_i      = 5'd3;
    bus.wb_data_i      = 32'h77;
    bus.wb_pc_add4_i   = 32'h40;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.ex_rt_data_o !== 32'h40)
      $display("FAIL jal_bypass: got %h want %h", act(), e);
    else passed++;
  endtask

  task automatic test_load_use();
    ex_t e;
    clr();
    set_instr(C_LW, 5'd2, 5'd9, 5'd0, 1'b0);
    step();
    void'(q.pop_front());
    set_instr(C_ADD, 5'd9, 5'd4, 5'd10, 1'b1);
    #1;
    total++;
    if (bus.stall_o !== 1'b1)
      $display("FAIL lu_stall: got %b want 1", bus.stall_o);
    else passed++;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.stall_cnt_o !== m_stall
        || bus.stall_cnt_o !== 16'd1 || bus.stall_o !== 1'b0)
      $display("FAIL lu_bubble: got %h cnt %0d stall %b want %h cnt 1",
               act(), bus.stall_cnt_o, bus.stall_o, e);
    else passed++;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.ex_valid_o !== 1'b1)
      $display("FAIL lu_capture: got %h want %h", act(), e);
    else passed++;
    set_instr(C_LW, 5'd2, 5'd9, 5'd0, 1'b0);
    step();
    void'(q.pop_front());
    set_instr(C_ADD, 5'd3, 5'd9, 5'd10, 1'b0);
    #1;
    total++;
    if (bus.stall_o !== 1'b0)
      $display("FAIL lu_no_rt: got %b want 0", bus.stall_o);
    else passed++;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e)
      $display("FAIL lu_no_rt_cap: got %h want %h", act(), e);
    else passed++;
  endtask

  task automatic test_flush_hold();
    ex_t e;
    clr();
    set_instr(C_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    step();
    void'(q.pop_front());
    set_instr(C_ADD, 5'd9, 5'd4, 5'd10, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    total++;
    if (bus.stall_o !== 1'b0)
      $display("FAIL flush_stall: got %b want 0", bus.stall_o);
    else passed++;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.flush_cnt_o !== m_flush
        || bus.stall_cnt_o !== m_stall)
      $display("FAIL flush_bubble: got %h f%0d s%0d want %h f%0d s%0d",
               act(), bus.flush_cnt_o, bus.stall_cnt_o,
               e, m_flush, m_stall);
    else passed++;
    bus.flush_i = 1'b0;
    set_instr(C_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    step();
    void'(q.pop_front());
    set_instr(C_ADD, 5'd9, 5'd4, 5'd10, 1'b1);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = q.pop_front();
      total++;
      if (act() !== e || bus.stall_o !== 1'b0
          || bus.stall_cnt_o !== m_stall
          || bus.flush_cnt_o !== m_flush)
        $display("FAIL hold_freeze: got %h want %h", act(), e);
      else passed++;
      bus.rs_data_i = $urandom;
    end
    bus.flush_i = 1'b1;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.flush_cnt_o !== m_flush)
      $display("FAIL flush_over_hold: got %h f%0d want %h f%0d",
               act(), bus.flush_cnt_o, e, m_flush);
    else passed++;
  endtask

  task automatic test_back_to_back();
    ex_t e;
    logic [4:0] regs [4];
    int errs;
    regs[0] = 5'd0;
    regs[1] = 5'd1;
    regs[2] = 5'd2;
    regs[3] = 5'd31;
    errs = 0;
    clr();
    for (int i = 0; i < 60; i++) begin
      set_instr(11'($urandom), regs[$urandom_range(0, 3)],
                regs[$urandom_range(0, 3)], 5'($urandom),
                1'($urandom));
      if ($urandom_range(0, 3) == 0) bus.ctrl_i[1] = 1'b1;
      bus.id_valid_i     = ($urandom_range(0, 5) != 0);
      bus.wb_reg_write_i = 1'($urandom);
      bus.wb_is_jal_i    = ($urandom_range(0, 3) == 0);
      bus.wb_addr_i      = regs[$urandom_range(0, 3)];
      bus.wb_data_i      = $urandom;
      bus.wb_pc_add4_i   = $urandom;
      bus.flush_i        = ($urandom_range(0, 7) == 0);
      bus.hold_i         = ($urandom_range(0, 7) == 0);
      step();
      e = q.pop_front();
      total++;
      if (act() !== e || bus.stall_cnt_o !== m_stall
          || bus.flush_cnt_o !== m_flush) begin
        errs++;
        if (errs < 5)
          $display("FAIL b2b[%0d]: got %h s%0d f%0d want %h s%0d f%0d",
                   i, act(), bus.stall_cnt_o, bus.flush_cnt_o,
                   e, m_stall, m_flush);
      end else passed++;
    end
    clr();
  endtask

  task automatic test_saturation();
    clr();
    bus.flush_i = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      step();
      void'(q.pop_front());
    end
    total++;
    if (bus.flush_cnt_o !== 16'hFFFF || m_flush !== 16'hFFFF)
      $display("FAIL flush_sat: got %h want ffff", bus.flush_cnt_o);
    else passed++;
    bus.flush_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    ex_t e;
    clr();
    set_instr(C_LW, 5'd1, 5'd7, 5'd0, 1'b0);
    step();
    void'(q.pop_front());
    set_instr(C_ADD, 5'd7, 5'd4, 5'd10, 1'b1);
    #1;
    total++;
    if (bus.stall_o !== 1'b1)
      $display("FAIL rstmid_pre: got %b want 1", bus.stall_o);
    else passed++;
    rst = 1'b1;
    step();
    e = q.pop_front();
    rst = 1'b0;
    #1;
    total++;
    if (act() !== e || bus.stall_o !== 1'b0
        || bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0)
      $display("FAIL rstmid: got %h s%0d f%0d stall %b want %h 0 0 0",
               act(), bus.stall_cnt_o, bus.flush_cnt_o,
               bus.stall_o, e);
    else passed++;
    step();
    e = q.pop_front();
    total++;
    if (act() !== e || bus.ex_valid_o !== 1'b1)
      $display("FAIL rstmid_cap: got %h want %h", act(), e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_jal();
    test_load_use();
    test_flush_hold();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
